// File: rtl/serpar_pkg.sv
// ----------------------------------------------------------------------------
// serpar_pkg
// Shared definitions for the serial-to-parallel receiver:
//   state_t       : receiver lock states (HUNT, SYNC, ACTIVE)
//   SERPAR_COMMA  : default alignment symbol (8'hBC)
//   SERPAR_IDLE   : default idle fill symbol (8'h7C)
// ----------------------------------------------------------------------------
package serpar_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [7:0] SERPAR_COMMA = 8'hBC;
    localparam logic [7:0] SERPAR_IDLE  = 8'h7C;

endpackage

// File: rtl/serpar_shifter.sv
// ----------------------------------------------------------------------------
// serpar_shifter
// Serial shift register and word bit counter for the receiver.
// Ports:
//   clk       : bit clock
//   rst       : asynchronous active-high reset
//   data_in   : serial line, MSB first
//   align     : force bit_cnt to 0 on this edge (COMMA found while hunting)
//   count_en  : bit counter runs (receiver is aligned); held at 0 otherwise
//   sreg_next : shift register contents including the bit sampled this edge
//   boundary  : this edge samples the last bit of an aligned word
// ----------------------------------------------------------------------------
module serpar_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    input  logic              align,
    input  logic              count_en,
    output logic [DATA_W-1:0] sreg_next,
    output logic              boundary
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  bit_cnt;

    // Word compares are done on the value that includes the incoming bit so
    // that a word is recognised on the very edge that samples its last bit.
    assign sreg_next = {sreg[DATA_W-2:0], data_in};
    assign boundary  = count_en && (bit_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            sreg <= sreg_next;
            if (align || !count_en) begin
                bit_cnt <= '0;
            end else if (bit_cnt == CNT_LAST) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_paralelo_rx_param.sv
// ----------------------------------------------------------------------------
// serial_paralelo_rx_param
// Serial-to-parallel receiver with COMMA-based word alignment and lock.
// The receiver hunts for COMMA at any bit offset, then needs LOCK_CNT
// consecutive aligned COMMAs to lock. While locked, non-idle words are
// delivered on data_out with a one-cycle valid_out pulse.
// Ports:
//   clk_32f   : bit clock (single domain)
//   reset     : asynchronous active-high reset
//   data_in   : serial line, MSB first
//   data_out  : last received non-idle data word
//   valid_out : one-cycle pulse when data_out is updated
//   active    : receiver locked
//   idle_out  : line carries COMMA/IDLE_SYM, or receiver unlocked
// Build option:
//   SERPAR_RX_LOS_EN : drop lock after MAX_GAP words without an aligned COMMA
// ----------------------------------------------------------------------------
module serial_paralelo_rx_param
    import serpar_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] COMMA    = DATA_W'(SERPAR_COMMA),
    parameter logic [DATA_W-1:0] IDLE_SYM = DATA_W'(SERPAR_IDLE),
    parameter int                LOCK_CNT = 4,
    parameter int                MAX_GAP  = 16
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              active,
    output logic              idle_out
);

    // Elaboration-time legality checks on the configuration.
    if (DATA_W < 4 || DATA_W > 16) begin : g_bad_data_w
        $error("serial_paralelo_rx_param: DATA_W must be 4..16");
    end
    if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock_cnt
        $error("serial_paralelo_rx_param: LOCK_CNT must be 1..15");
    end
    if (MAX_GAP < 2 || MAX_GAP > 255) begin : g_bad_max_gap
        $error("serial_paralelo_rx_param: MAX_GAP must be 2..255");
    end

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t            state;
    logic [3:0]        lock_cnt;
    logic [DATA_W-1:0] sreg_next;
    logic              boundary;
    logic              is_comma;
    logic              is_idle;
    logic              align;
    logic              lose_lock;

    assign is_comma = (sreg_next == COMMA);
    assign is_idle  = (sreg_next == IDLE_SYM);
    // While hunting, a COMMA at any bit offset defines the word alignment.
    assign align    = (state == HUNT) && is_comma;

    serpar_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk       (clk_32f),
        .rst       (reset),
        .data_in   (data_in),
        .align     (align),
        .count_en  (state != HUNT),
        .sreg_next (sreg_next),
        .boundary  (boundary)
    );

`ifdef SERPAR_RX_LOS_EN
    localparam logic [7:0] GAP_LAST = 8'(MAX_GAP - 1);

    logic [7:0] gap_cnt;

    // The word arriving now would be the MAX_GAP-th since the last COMMA.
    assign lose_lock = (state == ACTIVE) && boundary && !is_comma
                       && (gap_cnt == GAP_LAST);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state != ACTIVE || lose_lock) begin
            gap_cnt <= '0;
        end else if (boundary) begin
            gap_cnt <= is_comma ? 8'd0 : gap_cnt + 8'd1;
        end
    end
`else
    assign lose_lock = 1'b0;
`endif

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            lock_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            idle_out  <= 1'b1;
        end else begin
            valid_out <= 1'b0;
            case (state)
                HUNT: begin
                    if (is_comma) begin
                        lock_cnt <= 4'd1;
                        if (LOCK_TGT == 4'd1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    if (boundary) begin
                        if (is_comma) begin
                            lock_cnt <= lock_cnt + 4'd1;
                            if (lock_cnt + 4'd1 == LOCK_TGT) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state    <= HUNT;
                            lock_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (lose_lock) begin
                        state    <= HUNT;
                        lock_cnt <= '0;
                        active   <= 1'b0;
                        idle_out <= 1'b1;
                    end else if (boundary) begin
                        if (is_comma || is_idle) begin
                            idle_out <= 1'b1;
                        end else begin
                            data_out  <= sreg_next;
                            idle_out  <= 1'b0;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= HUNT;
                    lock_cnt <= '0;
                    active   <= 1'b0;
                    idle_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_paralelo_rx_param.md
SERIAL_PARALELO_RX_PARAM -- requirements
Module: serial_paralelo_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: symbol width in bits, legal 4..16.
REQ-002 SHALL have parameter COMMA, default 8'hBC: alignment symbol, DATA_W bits.
REQ-003 SHALL have parameter IDLE_SYM, default 8'h7C: idle fill symbol, DATA_W bits.
REQ-004 SHALL have parameter LOCK_CNT, default 4: consecutive aligned COMMAs required for lock, legal 1..15.
REQ-005 SHALL have parameter MAX_GAP, default 16: maximum words between COMMAs while locked, legal 2..255; used only with SERPAR_RX_LOS_EN.
REQ-006 SHALL have port clk_32f, input, 1 bit: bit clock; single clock domain.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port data_in, input, 1 bit: serial line, MSB first, one bit per clk_32f rising edge.
REQ-009 SHALL have port data_out, output, DATA_W bits: last received non-idle data word.
REQ-010 SHALL have port valid_out, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-011 SHALL have port active, output, 1 bit: receiver locked.
REQ-012 SHALL have port idle_out, output, 1 bit: line carries COMMA/IDLE_SYM, or receiver is unlocked.

Function
REQ-013 SHALL form sreg_next = {sreg[DATA_W-2:0], data_in} every edge; all symbol compares SHALL use sreg_next.
REQ-014 SHALL implement states HUNT, SYNC and ACTIVE, plus a bit counter bit_cnt of 0..DATA_W-1 and a lock counter.
REQ-015 HUNT: on sreg_next==COMMA at any edge, bit_cnt SHALL be set to 0 and the lock counter to 1; the next state SHALL be ACTIVE if LOCK_CNT==1, else SYNC.
REQ-016 SYNC/ACTIVE: bit_cnt SHALL increment and wrap from DATA_W-1 to 0; the edge where bit_cnt==DATA_W-1 is the word boundary.
REQ-017 SYNC at a boundary: a COMMA SHALL increment the lock counter and SHALL enter ACTIVE when the counter reaches LOCK_CNT; any other word SHALL return to HUNT with the lock counter cleared.
REQ-018 ACTIVE at a boundary: a COMMA or IDLE_SYM word SHALL register idle_out=1 and leave data_out unchanged.
REQ-019 ACTIVE at a boundary: any other word SHALL register data_out=word, idle_out=0 and valid_out=1 for exactly one cycle.
REQ-020 Latency SHALL be exactly one edge: outputs update at the edge that samples a word's last bit.
REQ-021 active SHALL be 1 only in ACTIVE; idle_out SHALL be 1 in HUNT and SYNC.
REQ-022 In HUNT/SYNC, valid_out SHALL be 0 and data_out SHALL hold.
REQ-023 Misaligned COMMAs (not at a boundary) in SYNC/ACTIVE SHALL be ignored.

Reset
REQ-024 While reset=1, irrespective of clk_32f: state=HUNT, sreg=0, bit_cnt=0, lock counter=0, gap counter=0, data_out=0, valid_out=0, active=0, idle_out=1.
REQ-025 Reset asserted mid-word or mid-lock SHALL discard all partial state; after release, lock SHALL require the full LOCK_CNT sequence again.

Configuration
REQ-026 With SERPAR_RX_LOS_EN defined, the block SHALL count words since the last boundary COMMA in ACTIVE, and SHALL return to HUNT (active=0, idle_out=1 on the next edge) when the count reaches MAX_GAP.
REQ-027 Without SERPAR_RX_LOS_EN, the gap counter SHALL not exist, and ACTIVE SHALL be left only by reset.

Structure
REQ-028 Package serpar_pkg SHALL hold the state enum (HUNT, SYNC, ACTIVE) and the default constants SERPAR_COMMA=8'hBC and SERPAR_IDLE=8'h7C.
REQ-029 Sub-module serpar_shifter SHALL contain sreg, sreg_next and bit_cnt with its align/clear input; the FSM and output registers SHALL stay in the top module.

Verification
REQ-030 Defaults; reset=1 for 3 cycles, then four back-to-back 0xBC words -> active rises at the 4th word's last-bit edge, valid_out stays 0.
REQ-031 Locked; send 0x5A, then 0x7C -> data_out=0x5A with a 1-cycle valid_out; on 0x7C idle_out=1 and data_out stays 0x5A.
REQ-032 Lock at 0xBC at a 3-bit offset, followed by 0xBC, 0xBC, 0x12 -> return to HUNT, active never asserted.
REQ-033 Locked; assert reset at bit 5 of data word 0xA5 -> all outputs at reset values immediately, and 4 new 0xBCs are needed to relock.
REQ-034 SERPAR_RX_LOS_EN, MAX_GAP=16; lock, then 16 words of 0x33 -> active falls after the 16th word; without the macro, active stays 1.
REQ-035 DATA_W=10, COMMA=10'h17C, LOCK_CNT=2; two 0x17C words then 0x2AA -> active after the 2nd word, data_out=0x2AA on the 3rd.
